// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, word-addressed instruction memory with a write port,
// one registered instruction per cycle towards decode, with stall, redirect and halt.
module instr_fetch #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [63:0] RESET_PC   = 64'h0,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Stall,
  input  logic          Redirect,
  input  logic [63:0]   Redirect_pc,
  input  logic          Imem_wr_en,
  input  logic [AW-1:0] Imem_wr_addr,
  input  logic [31:0]   Imem_wr_data,
  output logic [31:0]   Instruction,
  output logic [63:0]   Pc,
  output logic          Valid,
  output logic          Halted
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic [31:0] instr_next;
  logic [63:0] pc_out_next;
  logic        valid_next;
  logic        halted_next;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] fetch_word;
  logic        in_range;

  // The memory has no reset so its contents survive reset; the zero-word halt check
  // needs the word in the same cycle as the fetch, hence the asynchronous read.
  always_ff @(posedge Clk) begin
    if (Imem_wr_en) begin
      imem[Imem_wr_addr] <= Imem_wr_data;
    end
  end

  assign fetch_word = imem[pc_reg[AW+1:2]];
  assign in_range   = (pc_reg[63:AW+2] == '0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= RESET_PC;
      Instruction <= NOP;
      Pc          <= 64'h0;
      Valid       <= 1'b0;
      Halted      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      Instruction <= instr_next;
      Pc          <= pc_out_next;
      Valid       <= valid_next;
      Halted      <= halted_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = Instruction;
    pc_out_next = Pc;
    valid_next  = Valid;
    halted_next = Halted;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_RUN;
      end
      default: begin
        // Redirect wins over stall and halt and always inserts one bubble.
        if (Redirect) begin
          pc_next     = Redirect_pc & ~64'h3;
          instr_next  = NOP;
          valid_next  = 1'b0;
          halted_next = 1'b0;
          state_next  = ST_RUN;
        end else if (!Stall && (state_reg == ST_RUN)) begin
          if (!in_range || (fetch_word == 32'h0)) begin
            instr_next  = NOP;
            valid_next  = 1'b0;
            halted_next = 1'b1;
            state_next  = ST_HALT;
          end else begin
            instr_next  = fetch_word;
            pc_out_next = pc_reg;
            valid_next  = 1'b1;
            pc_next     = pc_reg + 64'd4;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle behavioural model checked every cycle,
// plus literal expectations at the scenario checkpoints.
module tb_instr_fetch;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        Clk;
  logic        Rst_n;
  logic        Stall;
  logic        Redirect;
  logic [63:0] Redirect_pc;
  logic        Imem_wr_en;
  logic [5:0]  Imem_wr_addr;
  logic [31:0] Imem_wr_data;
  logic [31:0] Instruction;
  logic [63:0] Pc;
  logic        Valid;
  logic        Halted;

  int vectors    = 0;
  int miscompares = 0;

  instr_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Stall        (Stall),
    .Redirect     (Redirect),
    .Redirect_pc  (Redirect_pc),
    .Imem_wr_en   (Imem_wr_en),
    .Imem_wr_addr (Imem_wr_addr),
    .Imem_wr_data (Imem_wr_data),
    .Instruction  (Instruction),
    .Pc           (Pc),
    .Valid        (Valid),
    .Halted       (Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: mode 0 = waiting for first edge after reset, 1 = fetching, 2 = stopped.
  logic [31:0] m_mem [DEPTH];
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_pcout;
  logic        m_valid;
  logic        m_halted;
  int          m_mode;

  task automatic model_reset();
    m_pc = 64'h0; m_instr = NOP; m_pcout = 64'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_mode = 0;
  endtask

  task automatic model_stop();
    m_valid = 1'b0; m_instr = NOP; m_halted = 1'b1; m_mode = 2;
  endtask

  task automatic model_step();
    logic [63:0] widx;
    logic [5:0]  a;
    if (!Rst_n) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (Redirect) begin
      m_pc = {Redirect_pc[63:2], 2'b00};
      m_instr = NOP; m_valid = 1'b0; m_halted = 1'b0; m_mode = 1;
    end else if (!Stall && m_mode == 1) begin
      widx = m_pc / 4;
      if (widx >= 64'(DEPTH)) begin
        model_stop();
      end else begin
        a = widx[5:0];
        if (m_mem[a] == 32'h0) begin
          model_stop();
        end else begin
          m_instr = m_mem[a]; m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
        end
      end
    end
    if (Imem_wr_en) m_mem[Imem_wr_addr] = Imem_wr_data;
  endtask

  always @(negedge Rst_n) model_reset();

  always @(posedge Clk) begin
    model_step();
    #1;
    vectors++;
    if (Instruction !== m_instr || Pc !== m_pcout || Valid !== m_valid || Halted !== m_halted) begin
      miscompares++;
      $display("FAIL model t=%0t got instr=%h pc=%h v=%b h=%b want instr=%h pc=%h v=%b h=%b",
               $time, Instruction, Pc, Valid, Halted, m_instr, m_pcout, m_valid, m_halted);
    end else begin
      $display("vec t=%0t instr=%h pc=%h v=%b h=%b", $time, Instruction, Pc, Valid, Halted);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge Clk);
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'h00A0_0093;
      1: return 32'h0020_8133;
      2: return 32'h0020_B023;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  initial begin
    Rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; Redirect_pc = 64'h0;
    Imem_wr_en = 1'b0; Imem_wr_addr = '0; Imem_wr_data = '0;

    // Load the whole memory while held in reset.
    for (int i = 0; i < DEPTH; i++) begin
      Imem_wr_en = 1'b1; Imem_wr_addr = 6'(i); Imem_wr_data = init_word(i);
      nxt();
    end
    Imem_wr_en = 1'b0;
    chk("rst_valid", 64'(Valid), 64'h0);
    chk("rst_instr", 64'(Instruction), 64'(NOP));
    chk("rst_pc", Pc, 64'h0);
    chk("rst_halted", 64'(Halted), 64'h0);

    // 1: startup latency
    Rst_n = 1'b1;
    nxt(); chk("t1_c1_valid", 64'(Valid), 64'h0);
    nxt(); chk("t1_c2_valid", 64'(Valid), 64'h1); chk("t1_c2_pc", Pc, 64'h0);
           chk("t1_c2_instr", 64'(Instruction), 64'h00A0_0093);
    nxt(); chk("t1_c3_pc", Pc, 64'h4); chk("t1_c3_instr", 64'(Instruction), 64'h0020_8133);
    nxt(); chk("t2_pc8", Pc, 64'h8);

    // 2: stall holds
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nxt(); chk("t2_stall_pc", Pc, 64'h8); chk("t2_stall_valid", 64'(Valid), 64'h1);
      chk("t2_stall_instr", 64'(Instruction), 64'h0020_B023);
    end
    Stall = 1'b0;
    nxt(); chk("t2_resume_pc", Pc, 64'hC); chk("t2_resume_instr", 64'(Instruction), 64'h1000_0003);

    // 3: redirect beats stall
    Stall = 1'b1; Redirect = 1'b1; Redirect_pc = 64'h20;
    nxt(); Stall = 1'b0; Redirect = 1'b0;
    chk("t3_bubble_valid", 64'(Valid), 64'h0); chk("t3_bubble_instr", 64'(Instruction), 64'(NOP));
    nxt(); chk("t3_valid", 64'(Valid), 64'h1); chk("t3_pc", Pc, 64'h20);
    chk("t3_instr", 64'(Instruction), 64'h1000_0008);

    // 4: zero word halts; redirect and write in the same cycle
    Redirect = 1'b1; Redirect_pc = 64'h0;
    Imem_wr_en = 1'b1; Imem_wr_addr = 6'd5; Imem_wr_data = 32'h0;
    nxt(); Redirect = 1'b0; Imem_wr_en = 1'b0;
    chk("t4_bubble_valid", 64'(Valid), 64'h0);
    repeat (5) nxt();
    chk("t4_last_pc", Pc, 64'h10); chk("t4_last_valid", 64'(Valid), 64'h1);
    nxt(); chk("t4_halted", 64'(Halted), 64'h1); chk("t4_halt_valid", 64'(Valid), 64'h0);
    for (int k = 0; k < 10; k++) begin
      nxt(); chk("t4_hold_halted", 64'(Halted), 64'h1); chk("t4_hold_valid", 64'(Valid), 64'h0);
    end
    Redirect = 1'b1; Redirect_pc = 64'h0;
    nxt(); Redirect = 1'b0;
    chk("t4_unhalt", 64'(Halted), 64'h0); chk("t4_unhalt_valid", 64'(Valid), 64'h0);
    nxt(); chk("t4_restart_pc", Pc, 64'h0); chk("t4_restart_valid", 64'(Valid), 64'h1);
    chk("t4_restart_instr", 64'(Instruction), 64'h00A0_0093);

    // 5: asynchronous reset mid-cycle
    nxt(); nxt(); nxt(); chk("t5_pc12", Pc, 64'hC);
    Rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(Valid), 64'h0); chk("t5_async_pc", Pc, 64'h0);
    chk("t5_async_instr", 64'(Instruction), 64'(NOP)); chk("t5_async_halted", 64'(Halted), 64'h0);
    nxt(); Rst_n = 1'b1;
    nxt(); chk("t5_idle_valid", 64'(Valid), 64'h0);
    nxt(); chk("t5_refetch_pc", Pc, 64'h0); chk("t5_refetch_valid", 64'(Valid), 64'h1);

    // Write to the word being fetched this edge: old data comes out, new data later.
    Imem_wr_en = 1'b1; Imem_wr_addr = 6'd1; Imem_wr_data = 32'hDEAD_BEEF;
    nxt(); Imem_wr_en = 1'b0;
    chk("wr_old_pc", Pc, 64'h4); chk("wr_old_instr", 64'(Instruction), 64'h0020_8133);
    Redirect = 1'b1; Redirect_pc = 64'h4;
    nxt(); Redirect = 1'b0;
    nxt(); chk("wr_new_pc", Pc, 64'h4); chk("wr_new_instr", 64'(Instruction), 64'hDEAD_BEEF);

    // 6: out-of-range targets halt, no aliasing
    Redirect = 1'b1; Redirect_pc = 64'h103;
    nxt(); Redirect = 1'b0; chk("t6_bubble_halted", 64'(Halted), 64'h0);
    nxt(); chk("t6_oor_halted", 64'(Halted), 64'h1); chk("t6_oor_valid", 64'(Valid), 64'h0);
    chk("t6_oor_instr", 64'(Instruction), 64'(NOP));
    Redirect = 1'b1; Redirect_pc = 64'h1_0000_0000;
    nxt(); Redirect = 1'b0; chk("t6_hi_bubble_halted", 64'(Halted), 64'h0);
    nxt(); chk("t6_hi_halted", 64'(Halted), 64'h1); chk("t6_hi_valid", 64'(Valid), 64'h0);

    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
